exec_txn_scoreboard: RTL
========================

EXEC_TXN_SCOREBOARD -- requirements
Module: exec_txn_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 8, expected-transaction queue depth, power of two, 2..64.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum cycles an expected transaction may wait at the queue head, 1..255.
REQ-003 SHALL have parameter AW, default `ADDR_WIDTH, memory address width.
REQ-004 SHALL have parameter DW, default `DATA_WIDTH, memory data width.
REQ-005 SHALL have ports: clk  in  1  free-running clock; reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: exp_valid in 1 push expected txn; exp_kind in 1 (0 = read, 1 = write); exp_addr in AW; exp_data in DW (write data, ignored for reads); exp_full out 1.
REQ-007 SHALL have ports: exec_rd_req in 1; exec_rd_addr in AW; exec_wr_req in 1; exec_wr_addr in AW; exec_wr_data in DW (observed DUT memory requests).
REQ-008 SHALL have ports: match out 1 pulse; mismatch out 1 pulse; err_code out 3 (valid with any error pulse); match_cnt out 16; err_cnt out 16; pending out $clog2(DEPTH)+1.

Function
REQ-009 SHALL store pushed {kind, addr, data} in FIFO order; pending = current occupancy; exp_full = (pending == DEPTH).
REQ-010 SHALL treat a request as observed only on its rising edge (low in the previous cycle, high now).
REQ-011 SHALL flag err_code DBL_STROBE and pulse mismatch when any request stays high for a second consecutive cycle, without popping the queue.
REQ-012 On an observed request with queue non-empty, SHALL pop the head and compare kind and addr, plus data for writes; all equal -> match pulse and match_cnt+1; otherwise mismatch, err_code KIND, ADDR, or DATA (checked in that priority).
REQ-013 On an observed request with queue empty, SHALL pulse mismatch with err_code UNEXPECTED; nothing is popped.
REQ-014 When exec_rd_req and exec_wr_req rise in the same cycle, SHALL pulse mismatch with err_code BOTH and pop nothing.
REQ-015 exp_valid while full SHALL be dropped and SHALL pulse mismatch with err_code OVERFLOW; a simultaneous pop frees one slot, so the push is then accepted.
REQ-016 Push and pop in one cycle SHALL leave pending unchanged; the newly pushed entry is never the one compared in that cycle.
REQ-017 All outputs SHALL be registered: a compare result appears one cycle after the request edge; match and mismatch are never high together.
REQ-018 err_cnt SHALL count every mismatch pulse; both counters saturate at 16'hFFFF.
REQ-019 If several errors coincide, SHALL report one pulse with the priority BOTH > DBL_STROBE > TIMEOUT > compare/UNEXPECTED > OVERFLOW, and SHALL increment err_cnt once.

Reset
REQ-020 While reset is high, SHALL empty the queue, clear edge history and the age counter, drive match = mismatch = 0, err_code = 0, both counters = 0, pending = 0, exp_full = 0.
REQ-021 Reset asserted mid-operation SHALL discard all queued entries with no error reported; the first rising edge after release is evaluated against the previous-cycle level 0.

Configuration
REQ-022 With SB_TIMEOUT_EN defined, an age counter SHALL run while the queue is non-empty and reset on each pop; reaching TIMEOUT SHALL pop the head, pulse mismatch with err_code TIMEOUT, and restart.
REQ-023 Without SB_TIMEOUT_EN, there SHALL be no age counter, the TIMEOUT parameter is unused, and entries wait indefinitely.

Structure
REQ-024 pdp8_pkg SHALL hold sb_kind_e, sb_txn_s {kind, addr, data}, and sb_err_e {NONE=0, KIND, ADDR, DATA, UNEXPECTED, BOTH, DBL_STROBE, OVERFLOW/TIMEOUT split as 3-bit codes 0-7 in that order, TIMEOUT sharing no code}; no literals are duplicated in the RTL.
REQ-025 The queue SHALL be one sub-module, sb_fifo, parametrised by DEPTH with element type sb_txn_s; comparison, edge detection and counters stay in the top level.

Verification
REQ-026 Push rd@0200, wr@0201 data 0017; DUT issues rd 0200, then wr 0201/0017 -> two match pulses, match_cnt = 2, pending = 0.
REQ-027 Push wr@0300 data 0005; DUT writes 0300/0006 -> mismatch, err_code DATA, err_cnt = 1.
REQ-028 Hold exec_rd_req high for 3 cycles at 0200 with one rd@0200 queued -> one match, then DBL_STROBE twice, err_cnt = 2.
REQ-029 DEPTH = 4: push 5 entries back-to-back -> OVERFLOW on the 5th push; repeat with a DUT request in the same cycle -> no overflow, pending = 4.
REQ-030 SB_TIMEOUT_EN, TIMEOUT = 16: push one entry and issue no request -> TIMEOUT pulse 16 cycles after the push, pending = 0.
REQ-031 Raise reset with 3 entries queued -> pending = 0, counters = 0, no pulse; a request after release -> UNEXPECTED.

Source files
------------

// File: rtl/pdp8_pkg.sv
// Shared types for the execution-transaction scoreboard: transaction kind,
// queued transaction record and the 3-bit error code.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

   localparam int SB_AW    = `ADDR_WIDTH;
   localparam int SB_DW    = `DATA_WIDTH;
   localparam int SB_ERR_W = 3;
   localparam int SB_CNT_W = 16;
   localparam int SB_AGE_W = 8;

   typedef enum logic {
      KIND_RD = 1'b0,
      KIND_WR = 1'b1
   } sb_kind_e;

   typedef struct packed {
      sb_kind_e          kind;
      logic [SB_AW-1:0]  addr;
      logic [SB_DW-1:0]  data;
   } sb_txn_s;

   typedef enum logic [SB_ERR_W-1:0] {
      ERR_NONE       = 3'd0,
      ERR_KIND       = 3'd1,
      ERR_ADDR       = 3'd2,
      ERR_DATA       = 3'd3,
      ERR_UNEXPECTED = 3'd4,
      ERR_BOTH       = 3'd5,
      ERR_DBL_STROBE = 3'd6,
      ERR_OVERFLOW   = 3'd7
   } sb_err_e;

   // All eight 3-bit codes are taken by NONE and the seven request/queue
   // errors. NONE never accompanies a mismatch pulse, so a mismatch pulse
   // carrying code 0 is unambiguously a head-of-queue timeout.
   localparam sb_err_e ERR_TIMEOUT = ERR_NONE;

endpackage

// File: rtl/sb_fifo.sv
// Expected-transaction queue. Head is visible combinationally so the
// comparison can consume it in the same cycle as the request edge.
// Count/full/empty are registered.
module sb_fifo
   import pdp8_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  sb_txn_s                push_txn,
   input  logic                   pop,
   output sb_txn_s                head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);

   sb_txn_s       mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic [PW:0]   count_next;
   logic          full_reg;
   logic          empty_reg;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         // each slot captures the pushed record when the write pointer selects it
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
               mem[gi] <= push_txn;
            end
         end
      end
   endgenerate

   // occupancy after this cycle's push/pop; both together leave it unchanged
   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + (PW+1)'(1);
         2'b01:   count_next = count_reg - (PW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   // pointers and registered status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_next;
         full_reg  <= (count_next == (PW+1)'(DEPTH));
         empty_reg <= (count_next == '0);
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = full_reg;
   assign empty = empty_reg;

endmodule

// File: rtl/exec_txn_scoreboard.sv
// Scoreboard comparing observed memory requests against a queue of expected
// transactions. Optional head-of-queue age limit enabled by SB_TIMEOUT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module exec_txn_scoreboard
   import pdp8_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 16,
   parameter int AW      = `ADDR_WIDTH,
   parameter int DW      = `DATA_WIDTH
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   exp_valid,
   input  logic                   exp_kind,
   input  logic [AW-1:0]          exp_addr,
   input  logic [DW-1:0]          exp_data,
   output logic                   exp_full,
   input  logic                   exec_rd_req,
   input  logic [AW-1:0]          exec_rd_addr,
   input  logic                   exec_wr_req,
   input  logic [AW-1:0]          exec_wr_addr,
   input  logic [DW-1:0]          exec_wr_data,
   output logic                   match,
   output logic                   mismatch,
   output logic [SB_ERR_W-1:0]    err_code,
   output logic [SB_CNT_W-1:0]    match_cnt,
   output logic [SB_CNT_W-1:0]    err_cnt,
   output logic [$clog2(DEPTH):0] pending
);

   logic          rd_prev_reg, wr_prev_reg;
   logic          rd_rise, wr_rise, both, dbl, obs;
   sb_kind_e      obs_kind;
   logic [SB_AW-1:0] obs_addr;
   logic [SB_DW-1:0] obs_data;
   logic          push, pop, hit, flag, timeout_hit;
   sb_err_e       err_next;
   sb_txn_s       push_txn, head;
   logic          fifo_full, fifo_empty;

   logic                match_reg, mismatch_reg;
   sb_err_e             err_code_reg;
   logic [SB_CNT_W-1:0] match_cnt_reg, err_cnt_reg;

   assign rd_rise  = exec_rd_req & ~rd_prev_reg;
   assign wr_rise  = exec_wr_req & ~wr_prev_reg;
   assign both     = rd_rise & wr_rise;
   assign dbl      = (exec_rd_req & rd_prev_reg) | (exec_wr_req & wr_prev_reg);
   assign obs      = rd_rise ^ wr_rise;
   assign obs_kind = wr_rise ? KIND_WR : KIND_RD;
   assign obs_addr = wr_rise ? SB_AW'(exec_wr_addr) : SB_AW'(exec_rd_addr);
   assign obs_data = SB_DW'(exec_wr_data);

   assign push_txn = '{kind: sb_kind_e'(exp_kind),
                       addr: SB_AW'(exp_addr),
                       data: SB_DW'(exp_data)};

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_txn (push_txn),
      .pop      (pop),
      .head     (head),
      .count    (pending),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

`ifdef SB_TIMEOUT_EN
   logic [SB_AGE_W-1:0] age_reg;

   assign timeout_hit = ~fifo_empty && (age_reg == SB_AGE_W'(TIMEOUT - 1));

   // age of the current head: idle while empty, restarts on every pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  age_reg <= '0;
      else if (fifo_empty || pop) age_reg <= '0;
      else                        age_reg <= age_reg + SB_AGE_W'(1);
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^SB_AGE_W'(TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   // pick the single event reported this cycle and decide push/pop;
   // only one pop per cycle, so a request coinciding with a timeout is absorbed
   always_comb begin
      pop      = 1'b0;
      hit      = 1'b0;
      flag     = 1'b0;
      err_next = ERR_NONE;
      if (both) begin
         flag     = 1'b1;
         err_next = ERR_BOTH;
      end else if (dbl) begin
         flag     = 1'b1;
         err_next = ERR_DBL_STROBE;
      end else if (timeout_hit) begin
         flag     = 1'b1;
         err_next = ERR_TIMEOUT;
         pop      = 1'b1;
      end else if (obs) begin
         if (fifo_empty) begin
            flag     = 1'b1;
            err_next = ERR_UNEXPECTED;
         end else begin
            pop = 1'b1;
            if (head.kind != obs_kind) begin
               flag     = 1'b1;
               err_next = ERR_KIND;
            end else if (head.addr != obs_addr) begin
               flag     = 1'b1;
               err_next = ERR_ADDR;
            end else if ((obs_kind == KIND_WR) && (head.data != obs_data)) begin
               flag     = 1'b1;
               err_next = ERR_DATA;
            end else begin
               hit = 1'b1;
            end
         end
      end
      push = exp_valid & (~fifo_full | pop);
      if (exp_valid && fifo_full && !pop && !flag) begin
         flag     = 1'b1;
         err_next = ERR_OVERFLOW;
      end
   end

   // edge history, registered result pulses and saturating counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_prev_reg   <= 1'b0;
         wr_prev_reg   <= 1'b0;
         match_reg     <= 1'b0;
         mismatch_reg  <= 1'b0;
         err_code_reg  <= ERR_NONE;
         match_cnt_reg <= '0;
         err_cnt_reg   <= '0;
      end else begin
         rd_prev_reg  <= exec_rd_req;
         wr_prev_reg  <= exec_wr_req;
         match_reg    <= hit;
         mismatch_reg <= flag;
         err_code_reg <= flag ? err_next : ERR_NONE;
         if (hit && (match_cnt_reg != '1)) match_cnt_reg <= match_cnt_reg + SB_CNT_W'(1);
         if (flag && (err_cnt_reg != '1))  err_cnt_reg   <= err_cnt_reg + SB_CNT_W'(1);
      end
   end

   assign match     = match_reg;
   assign mismatch  = mismatch_reg;
   assign err_code  = err_code_reg;
   assign match_cnt = match_cnt_reg;
   assign err_cnt   = err_cnt_reg;
   assign exp_full  = fifo_full;

endmodule
